// File: rtl/avalon_pkg.sv
// Shared Avalon-MM types and the byte-lane masking helper.
package avalon_pkg;

  localparam int unsigned AVALON_BYTES_PER_WORD = 4;

  typedef logic [8*AVALON_BYTES_PER_WORD-1:0] word_t;
  typedef logic [AVALON_BYTES_PER_WORD-1:0]   be_t;

  // Zero every byte lane whose enable bit is low.
  function automatic word_t be_mask(word_t w, be_t be);
    return w & {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

endpackage

// File: rtl/avalon_read_agent_if.sv
// Pipelined Avalon-MM read bundle shared by hosts and memory-backed agents.
interface AvalonMmRead;
  import avalon_pkg::*;

  logic [31:0] address;
  be_t         byteenable;
  logic        read;
  word_t       agent_to_host;
  logic        waitrequest;
  logic        readdatavalid;

  modport Agent (
    input  address, byteenable, read,
    output agent_to_host, waitrequest, readdatavalid
  );

  modport Host (
    output address, byteenable, read,
    input  agent_to_host, waitrequest, readdatavalid
  );

endinterface

// File: rtl/avalon_read_pipe.sv
// Valid-tagged data shift pipeline; data is forced to zero in empty slots.
module avalon_read_pipe
  import avalon_pkg::*;
#(
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  word_t in_data,
  output logic  out_valid,
  output word_t out_data
);

  logic  valid_q [READ_LATENCY];
  word_t data_q  [READ_LATENCY];

  for (genvar g = 0; g < READ_LATENCY; g++) begin : g_stage
    logic  prev_valid;
    word_t prev_data;

    if (g == 0) begin : g_head
      assign prev_valid = in_valid;
      assign prev_data  = in_valid ? in_data : '0;
    end else begin : g_body
      assign prev_valid = valid_q[g-1];
      assign prev_data  = data_q[g-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q[g] <= 1'b0;
        data_q[g]  <= '0;
      end else begin
        valid_q[g] <= prev_valid;
        data_q[g]  <= prev_data;
      end
    end
  end

  assign out_valid = valid_q[READ_LATENCY-1];
  assign out_data  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/avalon_read_agent.sv
// Memory-backed Avalon-MM read agent with wait states, fixed latency and
// a cap on outstanding reads.
module avalon_read_agent
  import avalon_pkg::*;
#(
  parameter int unsigned WORDS        = 1024,
  parameter int unsigned WAIT_STATES  = 0,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_PENDING  = 4,
  parameter string       INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst_n,
  AvalonMmRead.Agent  bus
);

  localparam int unsigned AW = $clog2(WORDS);
  localparam int unsigned PW = $clog2(MAX_PENDING + 1);

  word_t mem [WORDS] = '{default: '0};

  logic [3:0]    wait_cnt;
  logic [PW-1:0] pending;
  logic          free;
  logic          accept;
  logic          in_range;
  logic [AW-1:0] idx;
  word_t         rd_word;

  // A response retiring this cycle frees its slot for a new accept.
  assign free            = (pending < PW'(MAX_PENDING)) || bus.readdatavalid;
  assign bus.waitrequest = !rst_n ||
                           (bus.read && ((wait_cnt != 4'(WAIT_STATES)) || !free));
  assign accept          = bus.read && !bus.waitrequest;

  assign idx      = bus.address[AW+1:2];
  assign in_range = (bus.address >> (AW + 2)) == 32'd0;
  assign rd_word  = in_range ? be_mask(mem[idx], bus.byteenable) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (!bus.read || accept) begin
      wait_cnt <= '0;
    end else if (free && (wait_cnt < 4'(WAIT_STATES))) begin
      wait_cnt <= wait_cnt + 4'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else if (accept && !bus.readdatavalid) begin
      pending <= pending + PW'(1);
    end else if (!accept && bus.readdatavalid) begin
      pending <= pending - PW'(1);
    end
  end

  avalon_read_pipe #(
    .READ_LATENCY (READ_LATENCY)
  ) u_pipe (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_data   (rd_word),
    .out_valid (bus.readdatavalid),
    .out_data  (bus.agent_to_host)
  );

endmodule

// File: tb/tb_avalon_read_agent.sv
// Directed self-checking bench: three agent configurations on one clock.
module tb_avalon_read_agent;
  import avalon_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  AvalonMmRead bus_a ();
  AvalonMmRead bus_b ();
  AvalonMmRead bus_c ();

  avalon_read_agent #(.WORDS(16), .WAIT_STATES(0), .READ_LATENCY(2), .MAX_PENDING(4))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  avalon_read_agent #(.WORDS(16), .WAIT_STATES(0), .READ_LATENCY(3), .MAX_PENDING(1))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  avalon_read_agent #(.WORDS(16), .WAIT_STATES(2), .READ_LATENCY(2), .MAX_PENDING(4))
    dut_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  word_t t3_exp [4];
  word_t exp_data;
  logic  exp_wr;
  logic  exp_rdv;

  initial begin
    t3_exp = '{32'hA000_0000, 32'hA000_0001, 32'h1234_5678, 32'hA000_0003};
    rst_n = 1'b0;
    bus_a.read = 1'b1; bus_a.address = '0; bus_a.byteenable = 4'hF;
    bus_b.read = 1'b0; bus_b.address = '0; bus_b.byteenable = 4'hF;
    bus_c.read = 1'b0; bus_c.address = '0; bus_c.byteenable = 4'hF;
    #1;
    for (int i = 0; i < 16; i++) begin
      dut_a.mem[4'(i)] = 32'hA000_0000 | 32'(i);
      dut_b.mem[4'(i)] = 32'hA000_0000 | 32'(i);
      dut_c.mem[4'(i)] = 32'hA000_0000 | 32'(i);
    end
    dut_a.mem[2] = 32'h1234_5678;
    dut_b.mem[2] = 32'h1234_5678;
    dut_c.mem[2] = 32'h1234_5678;

    // Reset held with a read pending on the bus.
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("rst_wr",   32'(bus_a.waitrequest),   32'd1);
      check_eq("rst_rdv",  32'(bus_a.readdatavalid), 32'd0);
      check_eq("rst_data", bus_a.agent_to_host,      32'd0);
      next_cycle();
    end
    rst_n = 1'b1;
    bus_a.read = 1'b0;
    @(negedge clk);
    check_eq("rel_wr", 32'(bus_a.waitrequest), 32'd0);

    // Single reads, full and partial byte enables.
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      bus_a.read = 1'b1; bus_a.address = 32'h8; bus_a.byteenable = (k == 0) ? 4'hF : 4'b0101;
      @(negedge clk);
      check_eq("t2_wr", 32'(bus_a.waitrequest), 32'd0);
      next_cycle();
      bus_a.read = 1'b0;
      @(negedge clk);
      check_eq("t2_rdv_early", 32'(bus_a.readdatavalid), 32'd0);
      next_cycle();
      @(negedge clk);
      check_eq("t2_rdv",  32'(bus_a.readdatavalid), 32'd1);
      check_eq("t2_data", bus_a.agent_to_host, (k == 0) ? 32'h1234_5678 : 32'h0034_0078);
      next_cycle();
      @(negedge clk);
      check_eq("t2_rdv_after",  32'(bus_a.readdatavalid), 32'd0);
      check_eq("t2_data_after", bus_a.agent_to_host,      32'd0);
    end

    // Four back-to-back reads at full throughput.
    for (int c = 0; c < 7; c++) begin
      next_cycle();
      bus_a.read = (c < 4); bus_a.address = 32'(4 * c); bus_a.byteenable = 4'hF;
      @(negedge clk);
      if (c < 4) check_eq("t3_wr", 32'(bus_a.waitrequest), 32'd0);
      exp_rdv  = (c >= 2) && (c < 6);
      exp_data = exp_rdv ? t3_exp[2'(c - 2)] : 32'd0;
      check_eq("t3_rdv",  32'(bus_a.readdatavalid), 32'(exp_rdv));
      check_eq("t3_data", bus_a.agent_to_host,      exp_data);
    end

    // One outstanding read, latency 3: accepts every third cycle.
    for (int c = 0; c < 11; c++) begin
      next_cycle();
      bus_b.read = (c < 9); bus_b.address = 32'h4; bus_b.byteenable = 4'hF;
      @(negedge clk);
      exp_wr  = (c < 9) && ((c % 3) != 0);
      exp_rdv = (c > 0) && (c < 10) && ((c % 3) == 0);
      check_eq("t4_wr",   32'(bus_b.waitrequest),   32'(exp_wr));
      check_eq("t4_rdv",  32'(bus_b.readdatavalid), 32'(exp_rdv));
      check_eq("t4_data", bus_b.agent_to_host,      exp_rdv ? 32'hA000_0001 : 32'd0);
    end

    // Two wait states per command, two commands back to back.
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      bus_c.read = (c < 6); bus_c.address = 32'h8; bus_c.byteenable = 4'hF;
      @(negedge clk);
      exp_wr  = (c == 0) || (c == 1) || (c == 3) || (c == 4);
      exp_rdv = (c == 4) || (c == 7);
      check_eq("t5_wr",   32'(bus_c.waitrequest),   32'(exp_wr));
      check_eq("t5_rdv",  32'(bus_c.readdatavalid), 32'(exp_rdv));
      check_eq("t5_data", bus_c.agent_to_host,      exp_rdv ? 32'h1234_5678 : 32'd0);
    end

    // Out-of-range address, then an address with ignored low bits set.
    for (int c = 0; c < 5; c++) begin
      next_cycle();
      bus_a.read = (c < 2); bus_a.address = (c == 0) ? 32'd64 : 32'hB; bus_a.byteenable = 4'hF;
      @(negedge clk);
      exp_rdv  = (c == 2) || (c == 3);
      exp_data = (c == 3) ? 32'h1234_5678 : 32'd0;
      check_eq("t6_rdv",  32'(bus_a.readdatavalid), 32'(exp_rdv));
      check_eq("t6_data", bus_a.agent_to_host,      exp_data);
    end

    // Reset pulse with two reads in flight, then a clean read.
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      rst_n = (c != 2);
      bus_a.read = (c < 2) || (c == 6);
      bus_a.address = (c == 6) ? 32'h8 : 32'(4 * c);
      bus_a.byteenable = 4'hF;
      @(negedge clk);
      exp_rdv = (c == 8);
      check_eq("t7_rdv",  32'(bus_a.readdatavalid), 32'(exp_rdv));
      check_eq("t7_data", bus_a.agent_to_host,      exp_rdv ? 32'h1234_5678 : 32'd0);
      if (c == 6) check_eq("t7_wr", 32'(bus_a.waitrequest), 32'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
